// File: rtl/vip_crop_dec_if.sv
// Video stream bundle: line valid, frame sync and one pixel word.
//   href  - line valid, data meaningful when high
//   vsync - frame sync, high between frames
//   data  - pixel word, DW bits (all channels packed)
// master drives the stream, slave receives it.
interface vip_crop_dec_if #(
   parameter int DW = 8
) ();
   logic          href;
   logic          vsync;
   logic [DW-1:0] data;

   modport master (output href, output vsync, output data);
   modport slave  (input  href, input  vsync, input  data);
endinterface

// File: rtl/vip_crop_dec.sv
// Video crop and decimate stage.
// A window (crop_x, crop_y, crop_w, crop_h) is cut from each input frame and
// only one of every 2^dec_x pixels / 2^dec_y lines inside it is kept.
// Ports:
//   pclk, rst_n        - pixel clock, asynchronous active-low reset
//   enable             - 1 = crop/decimate, 0 = pass-through
//   crop_x/y/w/h       - window origin and size (input pixels/lines)
//   dec_x/y            - decimation exponents
//   in_bus  (slave)    - input stream (href, vsync, data)
//   out_bus (master)   - output stream, exactly one cycle behind the input
//   out_width/height   - output size of the last completed frame
//   frame_done         - one-cycle pulse when a frame ends
//   cfg_err            - window of the current frame is invalid
// Configuration is sampled only at frame start; output stays blank after
// reset until a complete frame start has been seen.
module vip_crop_dec #(
   parameter int BITS     = 8,
   parameter int CHANNELS = 1,
   parameter int WIDTH    = 1280,
   parameter int HEIGHT   = 960
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] crop_x,
   input  logic [15:0] crop_y,
   input  logic [15:0] crop_w,
   input  logic [15:0] crop_h,
   input  logic [1:0]  dec_x,
   input  logic [1:0]  dec_y,
   vip_crop_dec_if.slave  in_bus,
   vip_crop_dec_if.master out_bus,
   output logic [15:0] out_width,
   output logic [15:0] out_height,
   output logic        frame_done,
   output logic        cfg_err
);

   localparam int          DW    = BITS * CHANNELS;
   localparam logic [16:0] W_MAX = 17'(WIDTH);
   localparam logic [16:0] H_MAX = 17'(HEIGHT);

   // Saturating 16-bit increment.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   // True when the low 'dec' bits of an offset are all zero.
   function automatic logic dec_ok(input logic [15:0] off, input logic [1:0] dec);
      logic r;
      case (dec)
         2'd0:    r = 1'b1;
         2'd1:    r = (off[0] == 1'b0);
         2'd2:    r = (off[1:0] == 2'b00);
         2'd3:    r = (off[2:0] == 3'b000);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   logic        vs_d;
   logic        href_d;
   logic        frame_active;
   logic        sh_en;
   logic [15:0] sh_x, sh_y, sh_w, sh_h;
   logic [1:0]  sh_dx, sh_dy;
   logic [15:0] pix;
   logic [15:0] line;
   logic [15:0] line_px;
   logic [15:0] line_px_inc;
   logic [15:0] max_w;
   logic [15:0] lines_out;

   logic        frame_start;
   logic        frame_end;
   logic        line_end;
   logic [16:0] x_end, y_end;
   logic        in_win;
   logic        keep;
   logic        cfg_bad;

   assign frame_start = vs_d & ~in_bus.vsync;
   assign frame_end   = ~vs_d & in_bus.vsync;
   assign line_end    = href_d & ~in_bus.href;

   // 17-bit window ends so that origin+size can never wrap.
   assign x_end  = {1'b0, sh_x} + {1'b0, sh_w};
   assign y_end  = {1'b0, sh_y} + {1'b0, sh_h};
   assign in_win = (pix >= sh_x) && ({1'b0, pix} < x_end) &&
                   (line >= sh_y) && ({1'b0, line} < y_end);
   assign line_px_inc = sat_inc(line_px);

   // Validity of the live configuration, sampled at frame start.
   always_comb begin
      cfg_bad = 1'b0;
      if ((crop_w == 16'd0) || (crop_h == 16'd0) ||
          (({1'b0, crop_x} + {1'b0, crop_w}) > W_MAX) ||
          (({1'b0, crop_y} + {1'b0, crop_h}) > H_MAX)) begin
         cfg_bad = 1'b1;
      end else begin
         cfg_bad = 1'b0;
      end
   end

   // Keep decision for the pixel currently on the input.
   always_comb begin
      keep = 1'b0;
      if (!frame_active) begin
         keep = 1'b0;
      end else if (!sh_en) begin
         keep = in_bus.href;
      end else if (cfg_err) begin
         keep = 1'b0;
      end else begin
         keep = in_bus.href & in_win &
                dec_ok(pix - sh_x, sh_dx) & dec_ok(line - sh_y, sh_dy);
      end
   end

   // Edge history, frame-active flag and shadow configuration.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d         <= 1'b0;
         href_d       <= 1'b0;
         frame_active <= 1'b0;
         sh_en        <= 1'b0;
         sh_x         <= 16'd0;
         sh_y         <= 16'd0;
         sh_w         <= 16'd0;
         sh_h         <= 16'd0;
         sh_dx        <= 2'd0;
         sh_dy        <= 2'd0;
      end else begin
         vs_d   <= in_bus.vsync;
         href_d <= in_bus.href;
         if (frame_start) begin
            frame_active <= 1'b1;
            sh_en        <= enable;
            sh_x         <= crop_x;
            sh_y         <= crop_y;
            sh_w         <= crop_w;
            sh_h         <= crop_h;
            sh_dx        <= dec_x;
            sh_dy        <= dec_y;
         end
      end
   end

   // Pixel and line position; frame start wins over a same-cycle line end.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         pix  <= 16'd0;
         line <= 16'hFFFF;
      end else begin
         if (in_bus.href) begin
            pix <= sat_inc(pix);
         end else begin
            pix <= 16'd0;
         end
         if (frame_start) begin
            line <= 16'd0;
         end else if (line_end) begin
            line <= sat_inc(line);
         end
      end
   end

   // Output stream register: one cycle latency, data zeroed when not kept.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         out_bus.href  <= 1'b0;
         out_bus.vsync <= 1'b0;
         out_bus.data  <= '0;
      end else begin
         out_bus.href  <= keep;
         out_bus.vsync <= in_bus.vsync;
         out_bus.data  <= keep ? in_bus.data : {DW{1'b0}};
      end
   end

   // Running output size: pixels in this line, widest line, non-empty lines.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         line_px   <= 16'd0;
         max_w     <= 16'd0;
         lines_out <= 16'd0;
      end else if (frame_end) begin
         line_px   <= 16'd0;
         max_w     <= 16'd0;
         lines_out <= 16'd0;
      end else if (keep) begin
         line_px <= line_px_inc;
         if (line_px_inc > max_w) begin
            max_w <= line_px_inc;
         end
      end else if (line_end) begin
         if (line_px != 16'd0) begin
            lines_out <= sat_inc(lines_out);
         end
         line_px <= 16'd0;
      end
   end

   // Frame results and configuration error flag.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         out_width  <= 16'd0;
         out_height <= 16'd0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         // A frame cut short by reset never reports.
         if (frame_end && frame_active) begin
            out_width  <= max_w;
            // A line still open when vsync rises is counted too.
            out_height <= (line_px != 16'd0) ? sat_inc(lines_out) : lines_out;
            frame_done <= 1'b1;
         end else begin
            frame_done <= 1'b0;
         end
         if (frame_start) begin
            cfg_err <= enable ? cfg_bad : 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vip_crop_dec.sv
// Directed bench for vip_crop_dec with a 16x8 frame, 3 x 8-bit channels.
// Expected output pixels are queued with their due cycle when driven and
// popped by the output monitor.
module tb_vip_crop_dec;

   logic        pclk;
   logic        rst_n;
   logic        en;
   logic [15:0] cx, cy, cw, ch;
   logic [1:0]  ddx, ddy;
   logic [15:0] out_width, out_height;
   logic        frame_done, cfg_err;

   vip_crop_dec_if #(.DW(24)) in_bus ();
   vip_crop_dec_if #(.DW(24)) out_bus ();

   vip_crop_dec #(.BITS(8), .CHANNELS(3), .WIDTH(16), .HEIGHT(8)) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(en),
      .crop_x(cx), .crop_y(cy), .crop_w(cw), .crop_h(ch),
      .dec_x(ddx), .dec_y(ddy),
      .in_bus(in_bus), .out_bus(out_bus),
      .out_width(out_width), .out_height(out_height),
      .frame_done(frame_done), .cfg_err(cfg_err)
   );

   typedef struct {
      logic [23:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   logic [7:0]  fno      = 8'd0;

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled just after each rising edge.
   always begin
      @(posedge pclk);
      #1;
      n_tests++;
      assert (out_bus.vsync === (rst_n ? in_bus.vsync : 1'b0)) else begin
         n_fail++;
         $error("FAIL out_vsync: observed %b expected %b", out_bus.vsync, rst_n ? in_bus.vsync : 1'b0);
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         assert (exp_q[0].cyc >= cyc) else begin
            n_fail++;
            $error("FAIL missed_pixel: observed none expected %h at cycle %0d", exp_q[0].data, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
      if (out_bus.href === 1'b1) begin
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL extra_pixel: observed %h expected no output", out_bus.data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            assert (out_bus.data === e.data) else begin
               n_fail++;
               $error("FAIL pixel_data: observed %h expected %h", out_bus.data, e.data);
            end
            n_tests++;
            assert (cyc === e.cyc) else begin
               n_fail++;
               $error("FAIL pixel_latency: observed cycle %0d expected %0d", cyc, e.cyc);
            end
         end
      end else begin
         n_tests++;
         assert (out_bus.data === 24'd0) else begin
            n_fail++;
            $error("FAIL blank_data: observed %h expected 0", out_bus.data);
         end
      end
      if (frame_done === 1'b1) done_cnt++;
   end

   task automatic step(input logic vs, input logic hr, input logic [23:0] d);
      @(negedge pclk);
      in_bus.vsync = vs;
      in_bus.href  = hr;
      in_bus.data  = d;
   endtask

   // One 16x8 frame; chg_line>=0 changes crop_w mid-frame, rst_line>=0 pulses reset.
   task automatic run_frame(input logic f_en, input logic [15:0] fx, fy, fw, fh,
                            input logic [1:0] fdx, fdy, input int chg_line,
                            input logic [15:0] chg_w, input int rst_line);
      int mx, my, mw, mh, mdx, mdy, cnt, mwid, mhei, done0;
      bit men, merr, alive, k;
      logic [23:0] d;
      en = f_en; cx = fx; cy = fy; cw = fw; ch = fh; ddx = fdx; ddy = fdy;
      repeat (3) step(1'b1, 1'b0, 24'd0);
      step(1'b0, 1'b0, 24'd0);
      men = f_en; mx = fx; my = fy; mw = fw; mh = fh; mdx = fdx; mdy = fdy;
      merr = men && (mw == 0 || mh == 0 || mx + mw > 16 || my + mh > 8);
      alive = 1'b1; mwid = 0; mhei = 0; fno = fno + 8'd1;
      repeat (2) step(1'b0, 1'b0, 24'd0);
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, merr});
      for (int l = 0; l < 8; l++) begin
         if (l == chg_line) cw = chg_w;
         cnt = 0;
         for (int p = 0; p < 16; p++) begin
            d = {8'(l), 8'(p), fno};
            if (l == rst_line && p == 5) begin
               @(negedge pclk);
               rst_n = 1'b0;
               in_bus.href = 1'b1;
               in_bus.data = d;
               alive = 1'b0;
               #1;
               chk("rst_href", {31'd0, out_bus.href}, 32'd0);
               chk("rst_data", {8'd0, out_bus.data}, 32'd0);
               chk("rst_width", {16'd0, out_width}, 32'd0);
               chk("rst_height", {16'd0, out_height}, 32'd0);
            end else begin
               step(1'b0, 1'b1, d);
               if (l == rst_line && p == 7) rst_n = 1'b1;
               if (!alive) k = 1'b0;
               else if (!men) k = 1'b1;
               else if (merr) k = 1'b0;
               else k = (p >= mx) && (p < mx + mw) && (l >= my) && (l < my + mh) &&
                        (((p - mx) % (1 << mdx)) == 0) && (((l - my) % (1 << mdy)) == 0);
               if (k) begin
                  exp_q.push_back('{d, cyc + 1});
                  cnt++;
               end
            end
         end
         if (cnt > mwid) mwid = cnt;
         if (cnt > 0) mhei++;
         repeat (3) step(1'b0, 1'b0, 24'd0);
      end
      done0 = done_cnt;
      repeat (5) step(1'b1, 1'b0, 24'd0);
      chk("frame_done", done_cnt, done0 + (alive ? 1 : 0));
      chk("out_width", {16'd0, out_width}, alive ? mwid : 0);
      chk("out_height", {16'd0, out_height}, alive ? mhei : 0);
      chk("queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0; cx = 16'd0; cy = 16'd0; cw = 16'd0; ch = 16'd0; ddx = 2'd0; ddy = 2'd0;
      in_bus.vsync = 1'b1; in_bus.href = 1'b0; in_bus.data = 24'd0;
      repeat (3) @(negedge pclk);
      chk("reset_href", {31'd0, out_bus.href}, 32'd0);
      chk("reset_data", {8'd0, out_bus.data}, 32'd0);
      chk("reset_vsync", {31'd0, out_bus.vsync}, 32'd0);
      chk("reset_width", {16'd0, out_width}, 32'd0);
      chk("reset_height", {16'd0, out_height}, 32'd0);
      chk("reset_done", {31'd0, frame_done}, 32'd0);
      chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
      rst_n = 1'b1;
      // Basic crop, 4x3 window at (2,1).
      run_frame(1'b1, 16'd2, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, -1, 16'd0, -1);
      // Crop 8x6 with decimation by 2 in both directions.
      run_frame(1'b1, 16'd2, 16'd1, 16'd8, 16'd6, 2'd1, 2'd1, -1, 16'd0, -1);
      // Width changed mid-frame: current frame unaffected.
      run_frame(1'b1, 16'd2, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, 2, 16'd6, -1);
      // Next frame picks up the new width.
      run_frame(1'b1, 16'd2, 16'd1, 16'd6, 16'd3, 2'd0, 2'd0, -1, 16'd0, -1);
      // Window past the right edge: error frame, nothing output.
      run_frame(1'b1, 16'd14, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, -1, 16'd0, -1);
      // Valid window clears the error.
      run_frame(1'b1, 16'd2, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, -1, 16'd0, -1);
      // Pass-through.
      run_frame(1'b0, 16'd2, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, -1, 16'd0, -1);
      // Reset pulse during line 2.
      run_frame(1'b1, 16'd2, 16'd1, 16'd4, 16'd3, 2'd0, 2'd0, -1, 16'd0, 2);
      // Recovery frame with decimation on x only.
      run_frame(1'b1, 16'd0, 16'd0, 16'd16, 16'd8, 2'd2, 2'd0, -1, 16'd0, -1);
      repeat (3) step(1'b1, 1'b0, 24'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
